// File: rtl/dual_regfile.sv
// dual_regfile: integer + FP register files for a pipelined core, with a
// per-register busy scoreboard for long-latency operations.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   RegWriteW/FPRegWriteW writeback enables (integer / FP file)
//   RdW, ResultW,         writeback destination index and data
//   FP_ResultW
//   A1,A2 -> RD1,RD2      integer read ports (x0 hard-wired to zero)
//   FA1..FA3 -> FRD1..3   FP read ports (f0 is an ordinary register)
//   UseA*, UseFA*         source is actually consumed by the decode-stage op
//   IssueValid, IssueFP,  long-latency issue: marks the destination busy
//   IssueRd
//   StallD                decode must hold: a used source is still pending
//
// Reads are combinational with write-first bypass. The busy bits give set
// priority over a same-edge clear. StallD is built only from registered busy
// bits and the writeback inputs, so IssueValid never reaches it combinationally.

// One read port: bypassed data plus this port's stall contribution.
module dual_regfile_rdport #(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic [4:0]        addr_i,
  input  logic              use_i,
  input  logic [31:0][31:0] regs_i,
  input  logic [31:0]       busy_i,
  input  logic [31:0]       clr_i,
  input  logic              wen_i,
  input  logic [4:0]        wa_i,
  input  logic [31:0]       wd_i,
  output logic [31:0]       rd_o,
  output logic              stall_o
);
  always_comb begin
    rd_o = regs_i[addr_i];
    if (wen_i && (wa_i == addr_i)) rd_o = wd_i;
    // x0 must read zero even before the first reset clears the array.
    if (ZERO_R0 && (addr_i == 5'd0)) rd_o = '0;
  end

  // A source whose writeback lands this cycle is already satisfied by the bypass.
  assign stall_o = use_i & busy_i[addr_i] & ~clr_i[addr_i];
endmodule

module dual_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic        FPRegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic [31:0] FP_ResultW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic [4:0]  FA1,
  input  logic [4:0]  FA2,
  input  logic [4:0]  FA3,
  output logic [31:0] FRD1,
  output logic [31:0] FRD2,
  output logic [31:0] FRD3,
  input  logic        UseA1,
  input  logic        UseA2,
  input  logic        UseFA1,
  input  logic        UseFA2,
  input  logic        UseFA3,
  input  logic        IssueValid,
  input  logic        IssueFP,
  input  logic [4:0]  IssueRd,
  output logic        StallD
);
  localparam int NI = 2;
  localparam int NF = 3;

  logic [31:0][31:0] int_q, int_d;
  logic [31:0][31:0] fp_q, fp_d;
  logic [31:0]       busyI_q, busyI_d;
  logic [31:0]       busyF_q, busyF_d;

  logic        int_wen, fp_wen;
  logic [31:0] clrI, clrF, setI, setF;

  // Writes to x0 are dropped here, so neither the array, the bypass nor the
  // busy-clear ever sees them.
  assign int_wen = RegWriteW & (RdW != 5'd0);
  assign fp_wen  = FPRegWriteW;

  always_comb begin
    clrI = '0;
    clrF = '0;
    setI = '0;
    setF = '0;
    if (int_wen) clrI[RdW] = 1'b1;
    if (fp_wen)  clrF[RdW] = 1'b1;
    if (IssueValid) begin
      if (IssueFP)                 setF[IssueRd] = 1'b1;
      else if (IssueRd != 5'd0)    setI[IssueRd] = 1'b1;
    end
  end

  always_comb begin
    int_d = int_q;
    fp_d  = fp_q;
    if (int_wen) int_d[RdW] = ResultW;
    if (fp_wen)  fp_d[RdW]  = FP_ResultW;
    // Set after clear: a new issue to a register being written back wins.
    busyI_d    = (busyI_q & ~clrI) | setI;
    busyF_d    = (busyF_q & ~clrF) | setF;
    busyI_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_q   <= '0;
      fp_q    <= '0;
      busyI_q <= '0;
      busyF_q <= '0;
    end else begin
      int_q   <= int_d;
      fp_q    <= fp_d;
      busyI_q <= busyI_d;
      busyF_q <= busyF_d;
    end
  end

  logic [NI-1:0][4:0]  ia;
  logic [NI-1:0]       iuse, istall;
  logic [NI-1:0][31:0] ird;
  logic [NF-1:0][4:0]  fa;
  logic [NF-1:0]       fuse, fstall;
  logic [NF-1:0][31:0] frd;

  assign ia   = {A2, A1};
  assign iuse = {UseA2, UseA1};
  assign fa   = {FA3, FA2, FA1};
  assign fuse = {UseFA3, UseFA2, UseFA1};

  for (genvar g = 0; g < NI; g++) begin : g_irp
    dual_regfile_rdport #(.ZERO_R0(1'b1)) u_rp (
      .addr_i (ia[g]),
      .use_i  (iuse[g]),
      .regs_i (int_q),
      .busy_i (busyI_q),
      .clr_i  (clrI),
      .wen_i  (int_wen),
      .wa_i   (RdW),
      .wd_i   (ResultW),
      .rd_o   (ird[g]),
      .stall_o(istall[g])
    );
  end

  for (genvar g = 0; g < NF; g++) begin : g_frp
    dual_regfile_rdport #(.ZERO_R0(1'b0)) u_rp (
      .addr_i (fa[g]),
      .use_i  (fuse[g]),
      .regs_i (fp_q),
      .busy_i (busyF_q),
      .clr_i  (clrF),
      .wen_i  (fp_wen),
      .wa_i   (RdW),
      .wd_i   (FP_ResultW),
      .rd_o   (frd[g]),
      .stall_o(fstall[g])
    );
  end

  assign RD1    = ird[0];
  assign RD2    = ird[1];
  assign FRD1   = frd[0];
  assign FRD2   = frd[1];
  assign FRD3   = frd[2];
  assign StallD = (|istall) | (|fstall);
endmodule

// File: tb/tb_dual_regfile.sv
// Directed bench for dual_regfile. The stimulus process drives one cycle of
// inputs at a time and queues the hand-computed expected outputs; a monitor
// on the falling edge drains the queue and compares against the DUT.
module tb_dual_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW, FPRegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW, FP_ResultW;
  logic [4:0]  A1, A2, FA1, FA2, FA3;
  logic [31:0] RD1, RD2, FRD1, FRD2, FRD3;
  logic        UseA1, UseA2, UseFA1, UseFA2, UseFA3;
  logic        IssueValid, IssueFP;
  logic [4:0]  IssueRd;
  logic        StallD;

  always #5 clk = ~clk;

  dual_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .FPRegWriteW(FPRegWriteW), .RdW(RdW),
    .ResultW(ResultW), .FP_ResultW(FP_ResultW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .FA1(FA1), .FA2(FA2), .FA3(FA3), .FRD1(FRD1), .FRD2(FRD2), .FRD3(FRD3),
    .UseA1(UseA1), .UseA2(UseA2), .UseFA1(UseFA1), .UseFA2(UseFA2), .UseFA3(UseFA3),
    .IssueValid(IssueValid), .IssueFP(IssueFP), .IssueRd(IssueRd),
    .StallD(StallD)
  );

  typedef enum int {S_RD1, S_RD2, S_FRD1, S_FRD2, S_FRD3, S_STALL} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_v(input string name, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  // Monitor: whatever the stimulus queued for this cycle is checked here.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RD1:   act = RD1;
        S_RD2:   act = RD2;
        S_FRD1:  act = FRD1;
        S_FRD2:  act = FRD2;
        S_FRD3:  act = FRD3;
        default: act = {31'd0, StallD};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    RegWriteW = 0; FPRegWriteW = 0; RdW = 0; ResultW = 0; FP_ResultW = 0;
    A1 = 0; A2 = 0; FA1 = 0; FA2 = 0; FA3 = 0;
    UseA1 = 0; UseA2 = 0; UseFA1 = 0; UseFA2 = 0; UseFA3 = 0;
    IssueValid = 0; IssueFP = 0; IssueRd = 0;
  endtask

  // Advance one clock; inputs for the next cycle start from idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    // Reset with a write and an issue asserted: both must be ignored.
    rst_n = 0;
    RegWriteW = 1; RdW = 5; ResultW = 32'hFFFF_FFFF;
    FPRegWriteW = 1; FP_ResultW = 32'hFFFF_FFFF;
    IssueValid = 1; IssueRd = 5;
    @(posedge clk); @(posedge clk); #1;
    idle();
    rst_n = 1;

    // First cycle after reset: everything reads zero, no stall.
    A1 = 5; A2 = 31; FA1 = 5; FA2 = 0; FA3 = 31;
    UseA1 = 1; UseA2 = 1; UseFA1 = 1; UseFA2 = 1; UseFA3 = 1;
    expect_v("rst_rd1", S_RD1, 0);
    expect_v("rst_rd2", S_RD2, 0);
    expect_v("rst_frd1", S_FRD1, 0);
    expect_v("rst_frd2", S_FRD2, 0);
    expect_v("rst_frd3", S_FRD3, 0);
    expect_v("rst_stall", S_STALL, 0);
    tick();

    // Write x5 (bypass on A2 in the same cycle), then read from the array.
    RegWriteW = 1; RdW = 5; ResultW = 32'hDEAD_BEEF; A2 = 5;
    expect_v("byp_x5", S_RD2, 32'hDEAD_BEEF);
    tick();
    A1 = 5;
    expect_v("rd_x5", S_RD1, 32'hDEAD_BEEF);
    tick();

    // Writes to x0 are ignored, including the bypass.
    RegWriteW = 1; RdW = 0; ResultW = 32'h1234; A1 = 0;
    expect_v("x0_byp", S_RD1, 0);
    tick();
    A1 = 0;
    expect_v("x0_rd", S_RD1, 0);
    tick();

    // Simultaneous int and FP writes to index 7, both bypassed.
    RegWriteW = 1; FPRegWriteW = 1; RdW = 7;
    ResultW = 32'hA5A5_A5A5; FP_ResultW = 32'h1234_5678;
    A2 = 7; FA3 = 7;
    expect_v("byp_rd2", S_RD2, 32'hA5A5_A5A5);
    expect_v("byp_frd3", S_FRD3, 32'h1234_5678);
    tick();
    A2 = 7; FA3 = 7;
    expect_v("rd_x7", S_RD2, 32'hA5A5_A5A5);
    expect_v("rd_f7", S_FRD3, 32'h1234_5678);
    tick();

    // f0 is an ordinary register.
    FPRegWriteW = 1; RdW = 0; FP_ResultW = 32'hCAFE_0000;
    tick();
    FA2 = 0;
    expect_v("rd_f0", S_FRD2, 32'hCAFE_0000);
    tick();

    // FP issue to f3: no stall in the issue cycle, stall afterwards.
    IssueValid = 1; IssueFP = 1; IssueRd = 3; FA1 = 3; UseFA1 = 1;
    expect_v("iss_nocomb", S_STALL, 0);
    tick();
    FA1 = 3; UseFA1 = 1;
    expect_v("stall_n1", S_STALL, 1);
    tick();
    // An integer writeback to x3 must not release the FP busy bit.
    RegWriteW = 1; RdW = 3; ResultW = 32'h3; FA1 = 3; UseFA1 = 1;
    expect_v("stall_n2", S_STALL, 1);
    tick();
    FPRegWriteW = 1; RdW = 3; FP_ResultW = 32'h4049_0FDB; FA1 = 3; UseFA1 = 1;
    expect_v("release", S_STALL, 0);
    expect_v("release_d", S_FRD1, 32'h4049_0FDB);
    tick();
    FA1 = 3; UseFA1 = 1;
    expect_v("released", S_STALL, 0);
    tick();

    // Use qualifier on an integer busy bit.
    IssueValid = 1; IssueRd = 9;
    tick();
    A2 = 9; UseA2 = 0;
    expect_v("unused_src", S_STALL, 0);
    tick();
    A2 = 9; UseA2 = 1;
    expect_v("used_src", S_STALL, 1);
    tick();
    RegWriteW = 1; RdW = 9; ResultW = 32'h99; A2 = 9; UseA2 = 1;
    expect_v("wb_x9", S_STALL, 0);
    expect_v("wb_x9_d", S_RD2, 32'h99);
    tick();

    // Integer issue to x0 sets nothing.
    IssueValid = 1; IssueRd = 0;
    tick();
    A1 = 0; UseA1 = 1;
    expect_v("iss_x0", S_STALL, 0);
    tick();

    // Set wins over clear on the same edge.
    IssueValid = 1; IssueRd = 4; RegWriteW = 1; RdW = 4; ResultW = 32'h4444_4444;
    tick();
    A1 = 4; UseA1 = 1;
    expect_v("set_prio", S_STALL, 1);
    expect_v("set_prio_d", S_RD1, 32'h4444_4444);
    tick();
    RegWriteW = 1; RdW = 4; ResultW = 32'h55;
    tick();
    A1 = 4; UseA1 = 1;
    expect_v("x4_clear", S_STALL, 0);
    tick();

    // Reset mid-operation with f2 written and pending.
    FPRegWriteW = 1; RdW = 2; FP_ResultW = 32'h3F80_0000;
    tick();
    IssueValid = 1; IssueFP = 1; IssueRd = 2;
    tick();
    FA1 = 2; UseFA1 = 1;
    expect_v("pre_rst_st", S_STALL, 1);
    expect_v("pre_rst_f2", S_FRD1, 32'h3F80_0000);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    FA1 = 2; UseFA1 = 1; A1 = 5;
    expect_v("mid_rst_st", S_STALL, 0);
    expect_v("mid_rst_f2", S_FRD1, 0);
    expect_v("mid_rst_x5", S_RD1, 0);
    tick();
    FPRegWriteW = 1; RdW = 2; FP_ResultW = 32'h11;
    tick();
    FA1 = 2; UseFA1 = 1;
    expect_v("post_rst_f2", S_FRD1, 32'h11);
    expect_v("post_rst_st", S_STALL, 0);
    tick();

    // Let the monitor drain; a leftover entry means it never got checked.
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_regfile.md
DUAL_REGFILE -- requirements
Module: dual_regfile

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state updates on rising edge); rst_n input 1 (sampled only at the rising edge).
REQ-002 SHALL have write-side inputs from the writeback stage: RegWriteW 1 (integer write enable); FPRegWriteW 1 (FP write enable); RdW 5 (destination index); ResultW 32 (integer data); FP_ResultW 32 (FP data).
REQ-003 SHALL have integer read ports: A1, A2 input 5 (source index) -> RD1, RD2 output 32.
REQ-004 SHALL have FP read ports: FA1, FA2, FA3 input 5 -> FRD1, FRD2, FRD3 output 32.
REQ-005 SHALL have read-use qualifiers input 1 each: UseA1, UseA2, UseFA1, UseFA2, UseFA3 (source actually consumed by the instruction in decode).
REQ-006 SHALL have issue inputs for long-latency ops: IssueValid 1; IssueFP 1 (1 = destination is in the FP file); IssueRd 5.
REQ-007 SHALL output StallD 1, asserted when decode must hold because a source is pending.

Function
REQ-008 SHALL hold 32x32 integer registers; x0 reads 0 always, and writes to x0 are ignored.
REQ-009 SHALL hold 32x32 FP registers; f0 is an ordinary register.
REQ-010 SHALL write ResultW to int[RdW] at the rising edge when RegWriteW=1 and RdW!=0.
REQ-011 SHALL write FP_ResultW to fp[RdW] at the rising edge when FPRegWriteW=1.
REQ-012 SHALL make reads combinational, with write-first bypass:
- if RegWriteW=1, RdW!=0 and RdW==A1, then RD1=ResultW in the same cycle;
- RD2 behaves the same way with A2;
- FP ports behave the same way using FPRegWriteW and FP_ResultW.
REQ-013 SHALL treat RegWriteW and FPRegWriteW both high in one cycle as two independent writes to the respective files.
REQ-014 SHALL keep busy bits busyI[31:0] and busyF[31:0], where busyI[0] is constantly 0.
REQ-015 SHALL set busyI[IssueRd] or busyF[IssueRd] (selected by IssueFP) at the edge where IssueValid=1; an integer issue with IssueRd=0 sets nothing.
REQ-016 SHALL clear busyI[RdW] at an integer write edge and busyF[RdW] at an FP write edge.
REQ-017 SHALL give set priority when a set and a clear target the same bit on the same edge, so the bit ends at 1.
REQ-018 SHALL drive StallD=1 combinationally iff some used source has its busy bit set and that bit is not being cleared by a writeback in the same cycle.
REQ-019 SHALL never let StallD depend on IssueValid in the same cycle; no combinational path IssueValid->StallD.
REQ-020 SHALL not gate writes by StallD; writeback always completes.

Reset
REQ-021 SHALL, on a rising edge with rst_n=0:
- clear all int and FP registers to 0x00000000;
- clear all busy bits;
- ignore writes and issues in that cycle.
REQ-022 SHALL present RD*=0, FRD*=0 and StallD=0 for any addresses in the first cycle after reset.
REQ-023 SHALL, when reset is asserted mid-operation with pending busy bits, drop them all; a later writeback to that index writes the data normally.

Verification
REQ-024 SHALL cover write-then-read: write int x5=0xDEADBEEF; next cycle A1=5 -> RD1=0xDEADBEEF; also A1=0 -> RD1=0 after writing x0=0x1234.
REQ-025 SHALL cover same-cycle bypass: RegWriteW=1, RdW=7, ResultW=0xA5A5A5A5, A2=7 -> RD2=0xA5A5A5A5 in that cycle; the FP equivalent applies with FA3.
REQ-026 SHALL cover scoreboard stall and release: IssueValid, IssueFP=1, IssueRd=3 at cycle N; FA1=3, UseFA1=1 -> StallD=1 from cycle N+1; FP writeback f3 at cycle M -> StallD=0 in cycle M, and FRD1 equals the new data.
REQ-027 SHALL cover the use qualifier: busyI[9]=1, A2=9, UseA2=0 -> StallD=0; with UseA2=1 -> StallD=1.
REQ-028 SHALL cover set-over-clear: issue int rd=4 and writeback x4 on the same edge -> busyI[4]=1 afterwards and x4 holds the written data.
REQ-029 SHALL cover reset mid-operation: busyF[2]=1 and f2=0x3F800000, then apply rst_n=0 for one edge -> f2=0 and StallD=0 with FA1=2, UseFA1=1.
